// File: rtl/mem_stage_param.sv
// Parametrised memory stage between execute and writeback: registers execute results,
// performs byte-enabled loads/stores with optional wait states and a stall handshake.

module mem_stage_param_lane #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [ADDR_W-1:0] idx,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    logic [7:0] mem [DEPTH];

    // Every word is cleared on reset so loads after reset return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];
endmodule

module mem_stage_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int REG_AW   = 3,
    parameter int WAIT_CYC = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   mem_data_in,
    input  logic [REG_AW-1:0]   writeback_address_in,
    input  logic                writeback_en_in,
    input  logic                writeback_src_in,
    input  logic [DATA_W-1:0]   alu_data_in,
    output logic                stall_out,
    output logic                valid_out,
    output logic [REG_AW-1:0]   writeback_address_out,
    output logic                writeback_en_out,
    output logic                writeback_src_out,
    output logic [DATA_W-1:0]   alu_data_out,
    output logic [DATA_W-1:0]   mem_data_out,
    output logic                addr_err_out
);
    localparam int NUM_LANES = DATA_W / 8;
    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int CNT_W     = 4;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                        state, state_nxt;
    logic [CNT_W-1:0]              cnt, cnt_nxt;
    logic                          memop, is_load, oor, complete, stall;
    logic [ADDR_W-1:0]             idx;
    logic [NUM_LANES-1:0][7:0]     rd_data;

    assign memop    = valid_in & (we | writeback_src_in);
    assign is_load  = valid_in & writeback_src_in;
    assign idx      = alu_data_in[ADDR_W-1:0];
    assign complete = valid_in & ~stall;

    generate
        if (ADDR_W < DATA_W) begin : g_oor
            assign oor = |alu_data_in[DATA_W-1:ADDR_W];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt counts remaining stall cycles; the cycle that sees cnt==0 is the completion cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                if (memop && WAIT_CYC > 0) begin
                    stall     = 1'b1;
                    state_nxt = S_WAIT;
                    cnt_nxt   = CNT_W'(WAIT_CYC - 1);
                end
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (rst) stall = 1'b0;
    end

    assign stall_out = stall;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        mem_stage_param_lane #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .wr    (complete & we & ~oor & be[k]),
            .idx   (idx),
            .wdata (mem_data_in[8*k +: 8]),
            .rdata (rd_data[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out             <= 1'b0;
            writeback_address_out <= '0;
            writeback_en_out      <= 1'b0;
            writeback_src_out     <= 1'b0;
            alu_data_out          <= '0;
            mem_data_out          <= '0;
            addr_err_out          <= 1'b0;
        end else if (complete) begin
            valid_out             <= 1'b1;
            writeback_address_out <= writeback_address_in;
            writeback_en_out      <= writeback_en_in;
            writeback_src_out     <= writeback_src_in;
            alu_data_out          <= alu_data_in;
            mem_data_out          <= (is_load & ~oor) ? rd_data : '0;
            addr_err_out          <= memop & oor;
        end else begin
            // bubble: idle or stalled cycle, data registers hold
            valid_out        <= 1'b0;
            writeback_en_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage_param.sv
// Directed bench for mem_stage_param: a zero-wait instance driven from a vector table,
// and a three-wait-state instance exercised with hand-written stall sequences.

module tb_mem_stage_param;
    typedef struct packed {
        logic        v;
        logic        we;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [2:0]  wa;
        logic        wen;
        logic        src;
        logic [15:0] alu;
    } in_t;

    typedef struct {
        in_t         i;
        logic        e_v;
        logic        e_wen;
        logic [15:0] e_mdo;
        logic        e_err;
        logic [15:0] e_alu;
        logic [2:0]  e_wa;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  in0 = '0;
    in_t  in3 = '0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    logic        s0, v0, wen0, src0, err0;
    logic [2:0]  wa0;
    logic [15:0] alu0, mdo0;
    logic        s3, v3, wen3, src3, err3;
    logic [2:0]  wa3;
    logic [15:0] alu3, mdo3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_stage_param #(.DATA_W(16), .ADDR_W(6), .REG_AW(3), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .valid_in(in0.v), .we(in0.we), .be(in0.be),
        .mem_data_in(in0.wd), .writeback_address_in(in0.wa), .writeback_en_in(in0.wen),
        .writeback_src_in(in0.src), .alu_data_in(in0.alu), .stall_out(s0), .valid_out(v0),
        .writeback_address_out(wa0), .writeback_en_out(wen0), .writeback_src_out(src0),
        .alu_data_out(alu0), .mem_data_out(mdo0), .addr_err_out(err0));

    mem_stage_param #(.DATA_W(16), .ADDR_W(6), .REG_AW(3), .WAIT_CYC(3)) dut3 (
        .clk(clk), .rst(rst), .valid_in(in3.v), .we(in3.we), .be(in3.be),
        .mem_data_in(in3.wd), .writeback_address_in(in3.wa), .writeback_en_in(in3.wen),
        .writeback_src_in(in3.src), .alu_data_in(in3.alu), .stall_out(s3), .valid_out(v3),
        .writeback_address_out(wa3), .writeback_en_out(wen3), .writeback_src_out(src3),
        .alu_data_out(alu3), .mem_data_out(mdo3), .addr_err_out(err3));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cyc0(input in_t x);
        in0 = x;
        #1 chk("dut0 stall", {31'd0, s0}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic in_t mk(input logic v, input logic we, input logic [1:0] be,
                               input logic [15:0] wd, input logic [2:0] wa,
                               input logic wen, input logic src, input logic [15:0] alu);
        mk = '{v: v, we: we, be: be, wd: wd, wa: wa, wen: wen, src: src, alu: alu};
    endfunction

    // Present one op to dut3, counting stall cycles; returns one cycle after completion.
    task automatic op3(input in_t x, output int stalls);
        int k;
        in3 = x;
        stalls = 0;
        k = 0;
        #1;
        while (s3) begin
            if (k > 0) begin
                chk("dut3 valid_out in stall", {31'd0, v3}, 32'd0);
                chk("dut3 wb_en_out in stall", {31'd0, wen3}, 32'd0);
            end
            stalls++;
            k++;
            if (k > 20) begin
                chk("dut3 stall timeout", 32'd1, 32'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vt[12];

    initial begin
        int st, t1, t2;

        vt[0]  = '{mk(1,1,3,16'h5555,1,0,0,16'h0045), 1,0,16'h0000,1,16'h0045,1};
        vt[1]  = '{mk(1,0,0,16'h0000,2,1,1,16'h0005), 1,1,16'h0000,0,16'h0005,2};
        vt[2]  = '{mk(1,1,3,16'hBEEF,3,0,0,16'h0005), 1,0,16'h0000,0,16'h0005,3};
        vt[3]  = '{mk(1,0,0,16'h0000,4,1,1,16'h0005), 1,1,16'hBEEF,0,16'h0005,4};
        vt[4]  = '{mk(1,1,3,16'h1234,5,0,0,16'h0007), 1,0,16'h0000,0,16'h0007,5};
        vt[5]  = '{mk(1,1,2,16'hAB00,6,0,0,16'h0007), 1,0,16'h0000,0,16'h0007,6};
        vt[6]  = '{mk(1,0,0,16'h0000,7,1,1,16'h0007), 1,1,16'hAB34,0,16'h0007,7};
        vt[7]  = '{mk(0,1,3,16'hFFFF,1,1,0,16'h0007), 0,0,16'hAB34,0,16'h0007,7};
        vt[8]  = '{mk(1,0,0,16'h0000,2,1,1,16'h0007), 1,1,16'hAB34,0,16'h0007,2};
        vt[9]  = '{mk(1,0,0,16'h0000,3,1,0,16'h1234), 1,1,16'h0000,0,16'h1234,3};
        vt[10] = '{mk(1,0,0,16'h0000,4,1,1,16'h8007), 1,1,16'h0000,1,16'h8007,4};
        vt[11] = '{mk(1,0,0,16'h0000,5,1,1,16'h0040), 1,1,16'h0000,1,16'h0040,5};

        do_reset();
        chk("reset valid_out", {31'd0, v0}, 32'd0);
        chk("reset mem_data_out", {16'd0, mdo0}, 32'd0);
        chk("reset alu_data_out", {16'd0, alu0}, 32'd0);
        chk("reset stall dut3", {31'd0, s3}, 32'd0);

        // dirty both ends of memory, then reset must clear them
        cyc0(mk(1,1,3,16'hFFFF,0,0,0,16'h0000));
        cyc0(mk(1,1,3,16'hFFFF,0,0,0,16'h003F));
        cyc0(mk(1,0,0,16'h0000,6,1,1,16'h003F));
        chk("load idx 63 before reset", {16'd0, mdo0}, 32'h0000FFFF);
        in0 = '0;
        do_reset();
        chk("reset clears mem_data_out", {16'd0, mdo0}, 32'd0);
        chk("reset clears wb_addr_out", {29'd0, wa0}, 32'd0);
        chk("reset clears wb_src_out", {31'd0, src0}, 32'd0);
        for (int a = 0; a < 64; a++) begin
            cyc0(mk(1,0,0,16'h0000,1,1,1,16'(a)));
            chk($sformatf("sweep idx %0d data", a), {16'd0, mdo0}, 32'd0);
        end
        chk("sweep valid_out", {31'd0, v0}, 32'd1);

        for (int n = 0; n < 12; n++) begin
            cyc0(vt[n].i);
            chk($sformatf("vec %0d valid_out", n), {31'd0, v0}, {31'd0, vt[n].e_v});
            chk($sformatf("vec %0d wb_en_out", n), {31'd0, wen0}, {31'd0, vt[n].e_wen});
            chk($sformatf("vec %0d mem_data_out", n), {16'd0, mdo0}, {16'd0, vt[n].e_mdo});
            chk($sformatf("vec %0d addr_err_out", n), {31'd0, err0}, {31'd0, vt[n].e_err});
            chk($sformatf("vec %0d alu_data_out", n), {16'd0, alu0}, {16'd0, vt[n].e_alu});
            chk($sformatf("vec %0d wb_addr_out", n), {29'd0, wa0}, {29'd0, vt[n].e_wa});
            if (vt[n].i.v)
                chk($sformatf("vec %0d wb_src_out", n), {31'd0, src0}, {31'd0, vt[n].i.src});
        end
        in0 = '0;

        // three wait states: store low byte only, then load it back
        op3(mk(1,1,1,16'hFFC3,1,0,0,16'h0005), st);
        chk("w3 store stalls", st, 3);
        chk("w3 store valid_out", {31'd0, v3}, 32'd1);
        op3(mk(1,0,0,16'h0000,2,1,1,16'h0005), st);
        chk("w3 load stalls", st, 3);
        chk("w3 load data", {16'd0, mdo3}, 32'h000000C3);
        chk("w3 load wb_en_out", {31'd0, wen3}, 32'd1);
        chk("w3 load wb_src_out", {31'd0, src3}, 32'd1);
        t1 = cyc;
        op3(mk(1,0,0,16'h0000,3,1,1,16'h0005), st);
        t2 = cyc;
        chk("w3 back-to-back spacing", t2 - t1, 4);
        chk("w3 back-to-back data", {16'd0, mdo3}, 32'h000000C3);
        op3(mk(1,0,0,16'h0000,4,1,0,16'h0777), st);
        chk("w3 alu op stalls", st, 0);
        chk("w3 alu op alu_data_out", {16'd0, alu3}, 32'h00000777);
        chk("w3 alu op mem_data_out", {16'd0, mdo3}, 32'd0);
        op3(mk(1,0,0,16'h0000,5,1,1,16'h0005), st);
        in3 = '0;

        // reset while a store is waiting
        in3 = mk(1,1,3,16'hFFFF,6,0,0,16'h0009);
        #1 chk("w3 abort stall presented", {31'd0, s3}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("w3 stall during rst", {31'd0, s3}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        in3 = '0;
        #1;
        chk("w3 abort stall after", {31'd0, s3}, 32'd0);
        chk("w3 abort valid_out", {31'd0, v3}, 32'd0);
        chk("w3 abort mem_data_out", {16'd0, mdo3}, 32'd0);
        chk("w3 abort alu_data_out", {16'd0, alu3}, 32'd0);
        chk("w3 abort wb_addr_out", {29'd0, wa3}, 32'd0);
        chk("w3 abort wb_src_out", {31'd0, src3}, 32'd0);
        op3(mk(1,0,0,16'h0000,1,1,1,16'h0009), st);
        chk("w3 aborted store not written", {16'd0, mdo3}, 32'd0);
        chk("w3 post-abort stalls", st, 3);
        in3 = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
